filtro_iir_biquad_multicanal: RTL and testbench

Parametrised, time-multiplexed second-order IIR (biquad) filter for ADC sample streams: CANALES independent channels share one multiplier. Four coefficient sets are selectable per sample via Modo. Handshake is the same as the fixed 200 Hz low-pass stage: a Bandera_ADC request and a one-cycle Bandera_Listo result pulse, with the result ready within 10 clocks. It sits between the ADC capture logic and the DAC/output path.

---
 rtl/filtro_iir_biquad_multicanal_pkg.sv | 72 +++++++
 rtl/filtro_iir_biquad_multicanal_if.sv | 43 ++++
 rtl/filtro_iir_biquad_multicanal_saturador.sv | 33 +++
 rtl/filtro_iir_biquad_multicanal.sv | 190 +++++++++++++++++++
 tb/tb_filtro_iir_biquad_multicanal.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filtro_iir_biquad_multicanal_pkg.sv
// -----------------------------------------------------------------------------
// filtro_iir_pkg
// Shared definitions for the multichannel biquad filter:
//   - Modo codes (coefficient set selection)
//   - FSM state encoding (also exported on the debug port)
//   - Biquad coefficients b0..a2 per mode, Q9.16 in 25 bits, designed for an
//     8 kHz sample rate (RBJ biquads, Q = 0.7071, f0 = 200 Hz).
// No ports: package only.
// -----------------------------------------------------------------------------
package filtro_iir_pkg;

  localparam int N_COEF    = 25;
  localparam int FRAC_COEF = 16;

  typedef enum logic [1:0] {
    MODO_PASABAJO   = 2'd0,
    MODO_PASAALTO   = 2'd1,
    MODO_PASABANDA  = 2'd2,
    MODO_INTEGRADOR = 2'd3
  } modo_e;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    CARGA   = 3'd1,
    MAC     = 3'd2,
    ESCRIBE = 3'd3,
    LISTO   = 3'd4
  } estado_e;

  typedef logic signed [N_COEF-1:0] coef_t;

  // y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2 (a0 normalised to 1).
  typedef struct packed {
    coef_t b0;
    coef_t b1;
    coef_t b2;
    coef_t a1;
    coef_t a2;
  } coefs_t;

  // Low-pass 200 Hz: b0=0.005543 b1=0.011085 b2=0.005543 a1=-1.778632 a2=0.800803
  localparam coefs_t COEF_PASABAJO = '{
    b0:  25'sd363,    b1:  25'sd726,    b2: 25'sd363,
    a1: -25'sd116564, a2:  25'sd52481};

  // High-pass 200 Hz: b0=0.894859 b1=-1.789717 b2=0.894859, same poles.
  localparam coefs_t COEF_PASAALTO = '{
    b0:  25'sd58645,  b1: -25'sd117291, b2: 25'sd58645,
    a1: -25'sd116564, a2:  25'sd52481};

  // Band-pass centred at 200 Hz, 0 dB peak: b0=0.099599 b2=-0.099599.
  localparam coefs_t COEF_PASABANDA = '{
    b0:  25'sd6527,   b1:  25'sd0,      b2: -25'sd6527,
    a1: -25'sd116564, a2:  25'sd52481};

  // Integrator (test): b0 = 1.0, a1 = -1.0, so y = x + y1.
  localparam coefs_t COEF_INTEGRADOR = '{
    b0:  25'sd65536,  b1:  25'sd0,      b2: 25'sd0,
    a1: -25'sd65536,  a2:  25'sd0};

  function automatic coefs_t coefs_de_modo(input logic [1:0] modo);
    coefs_t c;
    case (modo)
      MODO_PASABAJO:  c = COEF_PASABAJO;
      MODO_PASAALTO:  c = COEF_PASAALTO;
      MODO_PASABANDA: c = COEF_PASABANDA;
      default:        c = COEF_INTEGRADOR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/filtro_iir_biquad_multicanal_if.sv
// -----------------------------------------------------------------------------
// filtro_iir_biquad_multicanal_if
// Sample request / result bus of the multichannel biquad.
//   Bandera_ADC  request, level-sampled whenever the filter is able to accept
//   Uk, Canal, Modo  request payload, captured only on the accepting edge
//   Yk           filtered sample, held until the next result
//   Bandera_Listo one-cycle pulse, Yk is new
//   Ocupado      a sample is being processed; requests are dropped, not queued
//   Error        one-cycle pulse, request rejected because Canal >= CANALES
//
// Handshake: there is no backpressure wire. Ocupado acts as the inverse of
// ready: a request (Bandera_ADC=1) is taken on a rising edge where the filter
// is idle (or in its last result cycle), and is silently ignored otherwise.
// Every accepted request with a valid Canal yields exactly one Bandera_Listo
// 8 edges later; every invalid one yields exactly one Error pulse 1 edge later.
// -----------------------------------------------------------------------------
interface filtro_iir_biquad_multicanal_if #(
  parameter int N       = 25,
  parameter int CANALES = 2
);
  localparam int CW = (CANALES > 1) ? $clog2(CANALES) : 1;

  logic                Bandera_ADC;
  logic signed [N-1:0] Uk;
  logic [CW-1:0]       Canal;
  logic [1:0]          Modo;
  logic signed [N-1:0] Yk;
  logic                Bandera_Listo;
  logic                Ocupado;
  logic                Error;

  // master: sample source (ADC capture side)
  modport master (
    output Bandera_ADC, Uk, Canal, Modo,
    input  Yk, Bandera_Listo, Ocupado, Error
  );

  // slave: the filter
  modport slave (
    input  Bandera_ADC, Uk, Canal, Modo,
    output Yk, Bandera_Listo, Ocupado, Error
  );
endinterface

// File: rtl/filtro_iir_biquad_multicanal_saturador.sv
// -----------------------------------------------------------------------------
// saturador_redondeo
// Combinational output stage: round half up, drop FRAC fractional bits and
// saturate the accumulator to an N-bit signed sample.
//   acc_i  2N+3-bit signed accumulator
//   y_o    N-bit signed result in [-2^(N-1), 2^(N-1)-1]
// -----------------------------------------------------------------------------
module saturador_redondeo #(
  parameter int N    = 25,
  parameter int FRAC = 16
) (
  input  logic signed [2*N+2:0] acc_i,
  output logic signed [N-1:0]   y_o
);
  localparam int AW = 2*N + 3;
  localparam logic signed [AW-1:0] RND  = AW'(64'sd1 <<< (FRAC-1));
  localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (N-1)) - 64'sd1);
  localparam logic signed [AW-1:0] MINV = AW'(-(64'sd1 <<< (N-1)));

  logic signed [AW-1:0] desp;

  always_comb begin
    // Arithmetic shift floors, so adding half an LSB first rounds half up.
    desp = (acc_i + RND) >>> FRAC;
    if (desp > MAXV) begin
      y_o = MAXV[N-1:0];
    end else if (desp < MINV) begin
      y_o = MINV[N-1:0];
    end else begin
      y_o = desp[N-1:0];
    end
  end
endmodule

// File: rtl/filtro_iir_biquad_multicanal.sv
// -----------------------------------------------------------------------------
// filtro_iir_biquad_multicanal
// Time-multiplexed biquad IIR for CANALES independent channels sharing one
// multiplier. Per-channel history (x1, x2, y1, y2) and last-used Modo live in
// registers; a change of Modo on a channel clears that channel's history.
//   Clk      clock, rising edge
//   Reset_n  synchronous active-low reset
//   bus      request/result bus (slave side), see the interface file
//   estado_o current FSM state, for debug/observation
// Timing: request accepted at edge k, Bandera_Listo after edge k+8, next
// request accepted at edge k+9.
// -----------------------------------------------------------------------------
module filtro_iir_biquad_multicanal
  import filtro_iir_pkg::*;
#(
  parameter int N       = 25,
  parameter int FRAC    = 16,
  parameter int CANALES = 2
) (
  input  logic    Clk,
  input  logic    Reset_n,
  filtro_iir_biquad_multicanal_if.slave bus,
  output estado_e estado_o
);
  localparam int CW    = (CANALES > 1) ? $clog2(CANALES) : 1;
  localparam int AW    = 2*N + 3;
  localparam int NTERM = 5;

  estado_e estado_q, estado_d;
  logic    ocupado, listo, en_carga, en_mac, en_escribe;

  // Registered request: the edge that accepts a request only captures it;
  // the FSM leaves REPOSO (or raises Error) one edge later.
  logic                acepta, canal_invalido;
  logic                req_pend_q, req_err_q;
  logic signed [N-1:0] req_uk_q;
  logic [CW-1:0]       req_canal_q;
  logic [1:0]          req_modo_q;
  logic                error_q;

  // Working operands, term order: x0, x1, x2, y1, y2 against b0, b1, b2, a1, a2.
  logic [2:0]            idx_q;
  logic signed [N-1:0]   op_q [NTERM];
  logic signed [N-1:0]   cf_q [NTERM];
  logic signed [AW-1:0]  acc_q;
  logic signed [2*N-1:0] prod;
  logic signed [N-1:0]   y_sat, yk_q;
  coefs_t                cf_sel;
  logic                  hist_ok;

  logic signed [N-1:0] x1_q [CANALES];
  logic signed [N-1:0] x2_q [CANALES];
  logic signed [N-1:0] y1_q [CANALES];
  logic signed [N-1:0] y2_q [CANALES];
  logic [1:0]          modo_ult_q [CANALES];

  // ---------------------------------------------------------------- request
  assign canal_invalido = int'(bus.Canal) >= CANALES;
  // LISTO is the last busy cycle; accepting there keeps the 9-clock cadence.
  assign acepta = bus.Bandera_ADC &&
                  (((estado_q == REPOSO) && !req_pend_q) || (estado_q == LISTO));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      req_pend_q  <= 1'b0;
      req_err_q   <= 1'b0;
      req_uk_q    <= '0;
      req_canal_q <= '0;
      req_modo_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      error_q <= (estado_q == REPOSO) && req_pend_q && req_err_q;
      if (acepta) begin
        req_pend_q  <= 1'b1;
        req_err_q   <= canal_invalido;
        req_uk_q    <= bus.Uk;
        req_canal_q <= bus.Canal;
        req_modo_q  <= bus.Modo;
      end else if (estado_q == REPOSO) begin
        req_pend_q  <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      estado_q <= REPOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO:  if (req_pend_q && !req_err_q) estado_d = CARGA;
      CARGA:   estado_d = MAC;
      MAC:     if (idx_q == 3'(NTERM-1)) estado_d = ESCRIBE;
      ESCRIBE: estado_d = LISTO;
      LISTO:   estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  always_comb begin
    ocupado    = (estado_q != REPOSO);
    listo      = (estado_q == LISTO);
    en_carga   = (estado_q == CARGA);
    en_mac     = (estado_q == MAC);
    en_escribe = (estado_q == ESCRIBE);
  end

  // --------------------------------------------------------------- datapath
  assign cf_sel  = coefs_de_modo(req_modo_q);
  assign hist_ok = (modo_ult_q[req_canal_q] == req_modo_q);
  assign prod    = (2*N)'(op_q[idx_q]) * (2*N)'(cf_q[idx_q]);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      idx_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < NTERM; i++) begin
        op_q[i] <= '0;
        cf_q[i] <= '0;
      end
    end else if (en_carga) begin
      idx_q   <= '0;
      acc_q   <= '0;
      op_q[0] <= req_uk_q;
      op_q[1] <= hist_ok ? x1_q[req_canal_q] : '0;
      op_q[2] <= hist_ok ? x2_q[req_canal_q] : '0;
      op_q[3] <= hist_ok ? y1_q[req_canal_q] : '0;
      op_q[4] <= hist_ok ? y2_q[req_canal_q] : '0;
      cf_q[0] <= N'(cf_sel.b0);
      cf_q[1] <= N'(cf_sel.b1);
      cf_q[2] <= N'(cf_sel.b2);
      cf_q[3] <= N'(cf_sel.a1);
      cf_q[4] <= N'(cf_sel.a2);
    end else if (en_mac) begin
      idx_q <= idx_q + 3'd1;
      // Feed-forward terms add, feedback terms subtract.
      if (idx_q < 3'd3) begin
        acc_q <= acc_q + AW'(prod);
      end else begin
        acc_q <= acc_q - AW'(prod);
      end
    end
  end

  saturador_redondeo #(.N(N), .FRAC(FRAC)) u_sat (
    .acc_i (acc_q),
    .y_o   (y_sat)
  );

  // History shifts by one sample; y1 keeps the saturated output.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int c = 0; c < CANALES; c++) begin
        x1_q[c]       <= '0;
        x2_q[c]       <= '0;
        y1_q[c]       <= '0;
        y2_q[c]       <= '0;
        modo_ult_q[c] <= 2'd0;
      end
    end else if (en_escribe) begin
      x1_q[req_canal_q]       <= op_q[0];
      x2_q[req_canal_q]       <= op_q[1];
      y1_q[req_canal_q]       <= y_sat;
      y2_q[req_canal_q]       <= op_q[3];
      modo_ult_q[req_canal_q] <= req_modo_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      yk_q <= '0;
    end else if (en_escribe) begin
      yk_q <= y_sat;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.Yk            = yk_q;
  assign bus.Bandera_Listo = listo;
  assign bus.Ocupado       = ocupado;
  assign bus.Error         = error_q;
  assign estado_o          = estado_q;

endmodule

// File: tb/tb_filtro_iir_biquad_multicanal.sv
// -----------------------------------------------------------------------------
// tb_filtro_iir_biquad_multicanal
// Bench for the multichannel biquad. Three channels so that an out-of-range
// Canal value exists. Expected outputs come from a behavioural model that
// evaluates the difference equation directly with 64-bit integers.
// -----------------------------------------------------------------------------
module tb_filtro_iir_biquad_multicanal;
  import filtro_iir_pkg::*;

  localparam int N       = 25;
  localparam int FRAC    = 16;
  localparam int CANALES = 3;
  localparam int CW      = (CANALES > 1) ? $clog2(CANALES) : 1;
  localparam longint YMAX = (64'sd1 <<< (N-1)) - 64'sd1;
  localparam longint YMIN = -(64'sd1 <<< (N-1));

  // ------------------------------------------------------- clock and reset
  logic    clk   = 1'b0;
  logic    rst_n = 1'b0;
  estado_e estado;

  always #5 clk = ~clk;

  filtro_iir_biquad_multicanal_if #(.N(N), .CANALES(CANALES)) bus ();

  filtro_iir_biquad_multicanal #(.N(N), .FRAC(FRAC), .CANALES(CANALES)) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .bus      (bus),
    .estado_o (estado)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ scoreboard
  int n_chk  = 0;
  int n_fail = 0;
  logic signed [N-1:0] exp_q[$];

  longint h_x1 [CANALES];
  longint h_x2 [CANALES];
  longint h_y1 [CANALES];
  longint h_y2 [CANALES];
  int     h_modo [CANALES];

  // Rows: modes 0..3. Columns: b0, b1, b2, a1, a2 scaled by 2^16.
  function automatic longint coef(input int m, input int i);
    longint t [4][5];
    t = '{'{363,   726,     363,   -116564, 52481},
          '{58645, -117291, 58645, -116564, 52481},
          '{6527,  0,       -6527, -116564, 52481},
          '{65536, 0,       0,     -65536,  0}};
    return t[m][i];
  endfunction

  function automatic void modelo_reset();
    for (int c = 0; c < CANALES; c++) begin
      h_x1[c] = 0; h_x2[c] = 0; h_y1[c] = 0; h_y2[c] = 0; h_modo[c] = 0;
    end
  endfunction

  function automatic longint modelo(input int ch, input int m, input longint x);
    longint acc, y;
    if (m != h_modo[ch]) begin
      h_x1[ch] = 0; h_x2[ch] = 0; h_y1[ch] = 0; h_y2[ch] = 0;
    end
    acc = coef(m, 0) * x + coef(m, 1) * h_x1[ch] + coef(m, 2) * h_x2[ch]
        - coef(m, 3) * h_y1[ch] - coef(m, 4) * h_y2[ch];
    y = (acc + (64'sd1 <<< (FRAC-1))) >>> FRAC;
    if (y > YMAX) y = YMAX;
    else if (y < YMIN) y = YMIN;
    h_x2[ch] = h_x1[ch]; h_x1[ch] = x;
    h_y2[ch] = h_y1[ch]; h_y1[ch] = y;
    h_modo[ch] = m;
    return y;
  endfunction

  function automatic longint uk_aleatorio();
    if ($urandom_range(0, 7) == 0)
      return ($urandom_range(0, 1) == 1) ? YMAX : YMIN;
    return longint'($urandom_range(0, 2097152)) - 64'sd1048576;
  endfunction

  // ---------------------------------------------------------- driver tasks
  task automatic aplicar_reset();
    rst_n = 1'b0;
    bus.Bandera_ADC = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelo_reset();
  endtask

  // One request on an idle filter; returns just after the Listo cycle is seen.
  task automatic transaccion(input int ch, input int m, input longint x, input string nombre);
    logic signed [N-1:0] e;
    int lat;
    e = N'(modelo(ch, m, x));
    bus.Bandera_ADC = 1'b1;
    bus.Canal = CW'(ch);
    bus.Modo  = 2'(m);
    bus.Uk    = N'(x);
    @(posedge clk); #1;
    bus.Bandera_ADC = 1'b0;
    n_chk++;
    if (bus.Ocupado !== 1'b0 || bus.Bandera_Listo !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_accept: Ocupado=%b Listo=%b, required 0 0", nombre, bus.Ocupado, bus.Bandera_Listo);
    end
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        n_chk++;
        if (bus.Ocupado !== 1'b1) begin
          n_fail++;
          $display("FAIL %s ocupado: got %b, required 1", nombre, bus.Ocupado);
        end
      end
      if (bus.Bandera_Listo === 1'b1) lat = i;
    end
    n_chk++;
    if (lat != 8) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required 8", nombre, lat);
    end
    n_chk++;
    if (bus.Yk !== e) begin
      n_fail++;
      $display("FAIL %s Yk: got %0d, required %0d", nombre, bus.Yk, e);
    end
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    bus.Bandera_ADC = 1'b0;
    bus.Uk = '0; bus.Canal = '0; bus.Modo = 2'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (bus.Yk !== '0 || bus.Bandera_Listo !== 1'b0 || bus.Ocupado !== 1'b0 || bus.Error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: Yk=%0d Listo=%b Ocupado=%b Error=%b, required all 0",
               bus.Yk, bus.Bandera_Listo, bus.Ocupado, bus.Error);
    end
    n_chk++;
    if (estado !== REPOSO) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required REPOSO", estado);
    end
    rst_n = 1'b1;
    modelo_reset();
  endtask

  task automatic test_integrador();
    transaccion(0, 3, 1000, "integ_1");
    transaccion(0, 3, 1000, "integ_2");
    transaccion(0, 3, 1000, "integ_3");
  endtask

  task automatic test_saturacion();
    aplicar_reset();
    transaccion(0, 3, YMAX, "sat_pos_1");
    transaccion(0, 3, YMAX, "sat_pos_2");
    aplicar_reset();
    transaccion(0, 3, YMIN, "sat_neg_1");
    transaccion(0, 3, YMIN, "sat_neg_2");
  endtask

  task automatic test_aislamiento();
    aplicar_reset();
    transaccion(0, 3, 500, "iso_ch0_a");
    transaccion(1, 3, 7,   "iso_ch1");
    transaccion(0, 3, 500, "iso_ch0_b");
  endtask

  task automatic test_cambio_modo();
    aplicar_reset();
    transaccion(0, 3, 1000, "modo_int_1");
    transaccion(0, 3, 1000, "modo_int_2");
    transaccion(0, 0, 1000, "modo_lp_clear");
    transaccion(0, 3, 1000, "modo_int_clear");
  endtask

  task automatic test_error();
    logic signed [N-1:0] yk_prev;
    int listos;
    yk_prev = bus.Yk;
    bus.Bandera_ADC = 1'b1;
    bus.Canal = CW'(CANALES);
    bus.Modo  = 2'd3;
    bus.Uk    = N'(123);
    @(posedge clk); #1;
    bus.Bandera_ADC = 1'b0;
    bus.Canal = '0;
    n_chk++;
    if (bus.Error !== 1'b0 || bus.Ocupado !== 1'b0) begin
      n_fail++;
      $display("FAIL error_early: Error=%b Ocupado=%b, required 0 0", bus.Error, bus.Ocupado);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.Error !== 1'b1 || bus.Ocupado !== 1'b0) begin
      n_fail++;
      $display("FAIL error_pulse: Error=%b Ocupado=%b, required 1 0", bus.Error, bus.Ocupado);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.Error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_width: Error=%b, required 0", bus.Error);
    end
    listos = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.Bandera_Listo === 1'b1 || bus.Ocupado === 1'b1) listos++;
    end
    n_chk++;
    if (listos != 0 || bus.Yk !== yk_prev) begin
      n_fail++;
      $display("FAIL error_no_result: busy/listo cycles=%0d Yk=%0d, required 0 and %0d", listos, bus.Yk, yk_prev);
    end
  endtask

  task automatic test_ocupado();
    logic signed [N-1:0] e;
    int lat, listos;
    e = N'(modelo(1, 3, 321));
    bus.Bandera_ADC = 1'b1;
    bus.Canal = CW'(1); bus.Modo = 2'd3; bus.Uk = N'(321);
    @(posedge clk); #1;
    bus.Bandera_ADC = 1'b0;
    lat = 0; listos = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.Bandera_Listo === 1'b1) begin
        listos++;
        if (lat == 0) lat = i;
      end
      bus.Bandera_ADC = 1'b0;
      if (i == 3) begin
        // Request during processing with different payload: must be dropped.
        bus.Bandera_ADC = 1'b1;
        bus.Canal = CW'(0); bus.Modo = 2'd0; bus.Uk = N'(-5000);
      end
    end
    n_chk++;
    if (lat != 8 || listos != 1) begin
      n_fail++;
      $display("FAIL busy_ignore: first Listo at %0d, Listo count %0d, required 8 and 1", lat, listos);
    end
    n_chk++;
    if (bus.Yk !== e) begin
      n_fail++;
      $display("FAIL busy_value: Yk=%0d, required %0d", bus.Yk, e);
    end
  endtask

  task automatic test_back_to_back();
    int recibidos, ciclos, ult;
    longint x;
    logic signed [N-1:0] e;
    recibidos = 0; ciclos = 0; ult = 0;
    x = uk_aleatorio();
    exp_q.push_back(N'(modelo(2, 2, x)));
    bus.Bandera_ADC = 1'b1;
    bus.Canal = CW'(2); bus.Modo = 2'd2; bus.Uk = N'(x);
    while (recibidos < 6 && ciclos < 100) begin
      @(posedge clk); #1;
      ciclos++;
      if (bus.Bandera_Listo === 1'b1) begin
        recibidos++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: unexpected result Yk=%0d", bus.Yk);
        end else begin
          e = exp_q.pop_front();
          if (bus.Yk !== e) begin
            n_fail++;
            $display("FAIL b2b_value %0d: Yk=%0d, required %0d", recibidos, bus.Yk, e);
          end
        end
        if (recibidos > 1) begin
          n_chk++;
          if (ciclos - ult != 9) begin
            n_fail++;
            $display("FAIL b2b_period: %0d cycles between results, required 9", ciclos - ult);
          end
        end
        ult = ciclos;
        if (recibidos < 6) begin
          x = uk_aleatorio();
          exp_q.push_back(N'(modelo(2, 2, x)));
          bus.Uk = N'(x);
        end else begin
          bus.Bandera_ADC = 1'b0;
        end
      end
    end
    bus.Bandera_ADC = 1'b0;
    n_chk++;
    if (recibidos != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 6", recibidos);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mac();
    int listos;
    transaccion(0, 3, 777, "pre_reset");
    bus.Bandera_ADC = 1'b1;
    bus.Canal = CW'(0); bus.Modo = 2'd3; bus.Uk = N'(5000);
    @(posedge clk); #1;
    bus.Bandera_ADC = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (bus.Yk !== '0 || bus.Bandera_Listo !== 1'b0 || bus.Ocupado !== 1'b0 || bus.Error !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: Yk=%0d Listo=%b Ocupado=%b Error=%b, required all 0",
               bus.Yk, bus.Bandera_Listo, bus.Ocupado, bus.Error);
    end
    rst_n = 1'b1;
    modelo_reset();
    listos = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.Bandera_Listo === 1'b1) listos++;
    end
    n_chk++;
    if (listos != 0) begin
      n_fail++;
      $display("FAIL mid_reset_listo: got %0d pulses, required 0", listos);
    end
    transaccion(0, 3, 42, "post_reset");
  endtask

  task automatic test_aleatorio();
    int modo_act [CANALES];
    int ch;
    for (int c = 0; c < CANALES; c++) modo_act[c] = 3;
    for (int t = 0; t < 40; t++) begin
      ch = $urandom_range(0, CANALES-1);
      if ($urandom_range(0, 4) == 0) modo_act[ch] = $urandom_range(0, 3);
      transaccion(ch, modo_act[ch], uk_aleatorio(), "random");
    end
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    bus.Bandera_ADC = 1'b0;
    bus.Uk = '0; bus.Canal = '0; bus.Modo = 2'd0;
    test_reset();
    test_integrador();
    test_saturacion();
    test_aislamiento();
    test_cambio_modo();
    test_error();
    test_ocupado();
    test_back_to_back();
    test_reset_mac();
    test_aleatorio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
